prev_value_scheduler: RTL and testbench

Shares one previous-sample history store between N_CH requester channels. A round-robin arbiter grants one channel per cycle. The granted channel's signed sample is written into that channel's history slot. The channel's prior sample is returned one cycle later. The block sits in front of the signed-sample datapath and replaces per-channel one-sample delay registers with a single scheduled resource.

---
 rtl/prev_value_scheduler.sv | 132 +++++++++++++
 tb/tb_prev_value_scheduler.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/prev_value_scheduler.sv
// rtl/prev_value_scheduler.sv - round-robin shared previous-sample history store
//
// Purpose:
//   N_CH requester channels share one history store. A round-robin arbiter
//   grants one channel per cycle. At the granted edge the channel's sample
//   is written into its slot, and the value that was previously in the slot
//   is returned on the response port one cycle later.
//
// Ports:
//   clk           in   system clock, all state on rising edge
//   rst           in   synchronous reset, active-high
//   req           in   [N_CH]    per-channel request, held until granted
//   sample_flat   in   [N_CH*W]  channel k sample at [k*W +: W], signed
//   clear         in   single-cycle pulse, invalidates all history slots
//   grant         out  [N_CH]    one-hot combinational grant (0 during rst)
//   resp_valid    out  one-cycle response strobe
//   resp_ch       out  [CW]      channel index of the response
//   resp_prev     out  [W]       previous sample (0 when resp_has_prev=0)
//   resp_has_prev out  1 when resp_ch held a valid sample before the access

module prev_value_scheduler #(
  parameter  int N_CH = 4,
  parameter  int W    = 4,
  localparam int CW   = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   req,
  input  logic [N_CH*W-1:0] sample_flat,
  input  logic              clear,
  output logic [N_CH-1:0]   grant,
  output logic              resp_valid,
  output logic [CW-1:0]     resp_ch,
  output logic [W-1:0]      resp_prev,
  output logic              resp_has_prev
);

  // Arbitration state and history storage
  logic [CW-1:0]   r_rr_ptr;
  logic [W-1:0]    r_hist [N_CH];
  logic [N_CH-1:0] r_valid;

  // Response registers
  logic            r_resp_valid;
  logic [CW-1:0]   r_resp_ch;
  logic [W-1:0]    r_resp_prev;
  logic            r_resp_has_prev;

  // Arbiter results
  logic [CW-1:0]   w_cand [N_CH];
  logic            w_gnt_any;
  logic [CW-1:0]   w_gnt_idx;
  logic [W-1:0]    w_gnt_sample;
  logic [CW-1:0]   w_next_ptr;

  // (base + off) mod N_CH; N_CH need not be a power of two.
  function automatic logic [CW-1:0] wrap_idx(input logic [CW-1:0] base,
                                             input int          off);
    int s;
    s = int'(base) + off;
    if (s >= N_CH) s = s - N_CH;
    return CW'(s);
  endfunction

  // Candidate order for this cycle: rr_ptr, rr_ptr+1, ... with wrap.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_cand[i] = wrap_idx(r_rr_ptr, i);
    end
  end

  // First requesting candidate in priority order wins.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!w_gnt_any && req[w_cand[i]]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_cand[i];
      end
    end
  end

  // Mux the winning channel's sample out of the flat bus.
  always_comb begin
    w_gnt_sample = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (w_gnt_idx == CW'(k)) w_gnt_sample = sample_flat[k*W +: W];
    end
  end

  assign w_next_ptr = wrap_idx(w_gnt_idx, 1);

  // A request seen during reset is not granted, so nothing is written.
  assign grant = (w_gnt_any && !rst) ? (N_CH'(1) << w_gnt_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr        <= '0;
      r_valid         <= '0;
      r_resp_valid    <= 1'b0;
      r_resp_ch       <= '0;
      r_resp_prev     <= '0;
      r_resp_has_prev <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        r_hist[k] <= '0;
      end
    end else begin
      if (clear) r_valid <= '0;

      if (w_gnt_any) begin
        // Response reflects pre-clear state of the slot.
        r_resp_valid    <= 1'b1;
        r_resp_ch       <= w_gnt_idx;
        r_resp_has_prev <= r_valid[w_gnt_idx];
        r_resp_prev     <= r_valid[w_gnt_idx] ? r_hist[w_gnt_idx] : '0;
        // Placed after the clear so the fresh write keeps its slot valid.
        r_hist[w_gnt_idx]  <= w_gnt_sample;
        r_valid[w_gnt_idx] <= 1'b1;
        r_rr_ptr           <= w_next_ptr;
      end else begin
        r_resp_valid <= 1'b0;
      end
    end
  end

  assign resp_valid    = r_resp_valid;
  assign resp_ch       = r_resp_ch;
  assign resp_prev     = r_resp_prev;
  assign resp_has_prev = r_resp_has_prev;

endmodule

// File: tb/tb_prev_value_scheduler.sv
// tb/tb_prev_value_scheduler.sv - directed scoreboard bench for prev_value_scheduler

module tb_prev_value_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] sample_flat;
  logic        clear;
  logic [3:0]  grant;
  logic        resp_valid;
  logic [1:0]  resp_ch;
  logic [3:0]  resp_prev;
  logic        resp_has_prev;

  prev_value_scheduler #(.N_CH(4), .W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .sample_flat   (sample_flat),
    .clear         (clear),
    .grant         (grant),
    .resp_valid    (resp_valid),
    .resp_ch       (resp_ch),
    .resp_prev     (resp_prev),
    .resp_has_prev (resp_has_prev)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ch;
    logic       has;
    logic [3:0] prev;
  } resp_t;

  resp_t      sb_q [$];
  resp_t      last_resp;
  logic [3:0] ref_hist [4];
  logic [3:0] ref_valid;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] smp(input logic [3:0] s3, input logic [3:0] s2,
                                      input logic [3:0] s1, input logic [3:0] s0);
    return {s3, s2, s1, s0};
  endfunction

  // One cycle: drive inputs after an edge, check the response produced by that
  // edge plus the combinational grant, then predict the next edge's response.
  task automatic step(input logic rs, input logic [3:0] rq, input logic [15:0] sm,
                      input logic clr, input logic [3:0] exp_g);
    resp_t e;
    int    k;
    @(posedge clk);
    #1;
    rst = rs; req = rq; sample_flat = sm; clear = clr;
    #4;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("resp_valid", 32'(resp_valid), 32'd1);
      chk("resp_ch", 32'(resp_ch), 32'(e.ch));
      chk("resp_has_prev", 32'(resp_has_prev), 32'(e.has));
      chk("resp_prev", 32'(resp_prev), 32'(e.prev));
      last_resp = e;
    end else begin
      chk("resp_idle_valid", 32'(resp_valid), 32'd0);
      chk("resp_hold_ch", 32'(resp_ch), 32'(last_resp.ch));
      chk("resp_hold_prev", 32'(resp_prev), 32'(last_resp.prev));
      chk("resp_hold_has", 32'(resp_has_prev), 32'(last_resp.has));
    end
    chk("grant", 32'(grant), 32'(exp_g));
    if (rs) begin
      ref_valid = '0;
      for (int i = 0; i < 4; i++) ref_hist[i] = '0;
      sb_q.delete();
      last_resp = '{ch: 2'd0, has: 1'b0, prev: 4'd0};
    end else begin
      if (clr) ref_valid = '0;
      if (exp_g != 4'b0000) begin
        k = 0;
        for (int i = 0; i < 4; i++) if (exp_g[i]) k = i;
        e.ch   = 2'(k);
        e.has  = ref_valid[k] | (clr ? 1'b0 : 1'b0);
        e.prev = 4'd0;
        sb_q.push_back(e);
      end
    end
  endtask

  // Predicted response must use pre-clear validity; this tracks it separately.
  logic [3:0] pre_valid;

  task automatic access(input logic rs, input logic [3:0] rq, input logic [15:0] sm,
                        input logic clr, input logic [3:0] exp_g);
    int k;
    pre_valid = ref_valid;
    step(rs, rq, sm, clr, exp_g);
    if (!rs && exp_g != 4'b0000) begin
      k = 0;
      for (int i = 0; i < 4; i++) if (exp_g[i]) k = i;
      sb_q[sb_q.size()-1].has  = pre_valid[k];
      sb_q[sb_q.size()-1].prev = pre_valid[k] ? ref_hist[k] : 4'd0;
      ref_hist[k]  = sm[k*4 +: 4];
      ref_valid[k] = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; sample_flat = '0; clear = 1'b0;
    ref_valid = '0;
    for (int i = 0; i < 4; i++) ref_hist[i] = '0;
    last_resp = '{ch: 2'd0, has: 1'b0, prev: 4'd0};
    @(posedge clk);
    @(posedge clk);
    #5;
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_resp_ch", 32'(resp_ch), 32'd0);
    chk("reset_resp_prev", 32'(resp_prev), 32'd0);
    chk("reset_resp_has", 32'(resp_has_prev), 32'd0);

    // 1: single requester on ch0, +3, -5, -8
    access(1'b0, 4'b0001, smp(4'd0, 4'd0, 4'd0, 4'd3),  1'b0, 4'b0001);
    access(1'b0, 4'b0001, smp(4'd0, 4'd0, 4'd0, 4'hB),  1'b0, 4'b0001);
    access(1'b0, 4'b0001, smp(4'd0, 4'd0, 4'd0, 4'h8),  1'b0, 4'b0001);
    access(1'b0, 4'b0000, 16'h0000, 1'b0, 4'b0000);
    chk("t1_last_prev_minus5", 32'(resp_prev), 32'h0000000B);
    access(1'b1, 4'b0000, 16'h0000, 1'b0, 4'b0000);

    // 2: all channels requesting, two full rounds
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        access(1'b0, 4'b1111, smp(4'hE, 4'hF, 4'd2, 4'd1), 1'b0, 4'(1 << c));
      end
    end
    access(1'b0, 4'b0000, 16'h0000, 1'b0, 4'b0000);
    chk("t2_last_prev_minus2", 32'(resp_prev), 32'h0000000E);

    // 3: pointer at 2 after ch1 grant, then wrap to ch0
    access(1'b0, 4'b0010, smp(4'd0, 4'd0, 4'd5, 4'd0), 1'b0, 4'b0010);
    access(1'b0, 4'b1011, smp(4'd6, 4'd0, 4'd5, 4'd0), 1'b0, 4'b1000);
    access(1'b0, 4'b0011, smp(4'd0, 4'd0, 4'd5, 4'd4), 1'b0, 4'b0001);

    // 4: clear alone invalidates ch2 history
    access(1'b0, 4'b0100, smp(4'd0, 4'd7, 4'd0, 4'd0), 1'b0, 4'b0100);
    access(1'b0, 4'b0000, 16'h0000, 1'b1, 4'b0000);
    access(1'b0, 4'b0100, smp(4'd0, 4'd1, 4'd0, 4'd0), 1'b0, 4'b0100);
    access(1'b0, 4'b0100, smp(4'd0, 4'hC, 4'd0, 4'd0), 1'b0, 4'b0100);
    access(1'b0, 4'b0000, 16'h0000, 1'b0, 4'b0000);
    chk("t4_prev_plus1", 32'(resp_prev), 32'd1);

    // 5: clear coinciding with a ch1 grant
    access(1'b0, 4'b0010, smp(4'd0, 4'd0, 4'd4, 4'd0), 1'b0, 4'b0010);
    access(1'b0, 4'b0010, smp(4'd0, 4'd0, 4'hD, 4'd0), 1'b1, 4'b0010);
    access(1'b0, 4'b0010, smp(4'd0, 4'd0, 4'd0, 4'd0), 1'b0, 4'b0010);
    chk("t5_prev_plus4", 32'(resp_prev), 32'd4);
    access(1'b0, 4'b0001, smp(4'd0, 4'd0, 4'd0, 4'd2), 1'b0, 4'b0001);
    chk("t5_ch1_prev_minus3", 32'(resp_prev), 32'h0000000D);
    access(1'b0, 4'b0000, 16'h0000, 1'b0, 4'b0000);
    chk("t5_ch0_has_prev", 32'(resp_has_prev), 32'd0);

    // 6: reset with a pending request, pointer restarts at 0
    access(1'b1, 4'b0100, smp(4'd0, 4'd3, 4'd0, 4'd0), 1'b0, 4'b0000);
    access(1'b0, 4'b1100, smp(4'd2, 4'd5, 4'd0, 4'd0), 1'b0, 4'b0100);
    access(1'b0, 4'b0000, 16'h0000, 1'b0, 4'b0000);
    access(1'b0, 4'b0000, 16'h0000, 1'b0, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
